// File: rtl/output_stream_packer_pkg.sv
// Shared accelerator constants for the output stream path.
// PPU vector geometry and AXI-Stream beat width.
package output_stream_packer_pkg;
  localparam int ARRAY_COL = 16;
  localparam int PPU_W     = ARRAY_COL * 8;
  localparam int AXIS_W    = 64;
endpackage

// File: rtl/output_stream_packer_if.sv
// AXI-Stream beat bundle leaving the packer.
// master drives data/valid/last, slave drives ready.
interface output_stream_packer_if
  import output_stream_packer_pkg::*;
#(
  parameter int W = AXIS_W
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/output_stream_packer_sync_fifo.sv
// Synchronous FIFO, head word readable without a pop.
// A push is taken when full only if a pop frees a slot.
module sync_fifo
  import output_stream_packer_pkg::*;
#(
  parameter int W          = PPU_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                sys_rst_n,
  input  logic                clr,
  input  logic                push,
  input  logic [W-1:0]        wr_data,
  input  logic                pop,
  output logic [W-1:0]        rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [W-1:0]          mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clr)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/output_stream_packer.sv
// Buffers PPU vectors and emits each as a low/high beat
// pair on AXI-Stream, with optional packet framing.
module output_stream_packer
  import output_stream_packer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int OUT_W      = AXIS_W,
  parameter int IN_W       = PPU_W
) (
  input  logic                     clk,
  input  logic                     sys_rst_n,
  input  logic                     i_valid,
  input  logic [IN_W-1:0]          i_data_vec,
  input  logic [15:0]              cfg_vecs_per_pkt,
  input  logic                     i_pkt_start,
  output_stream_packer_if.master   m_axis,
  output logic [DEPTH_LOG2:0]      o_fifo_level,
  output logic                     o_overflow,
  output logic                     o_busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  state_e          state;
  logic [IN_W-1:0] vec_q;
  logic [IN_W-1:0] head;
  logic [15:0]     vec_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            accept;
  logic            pop;
  logic            last_hit;

  assign accept   = m_axis.tvalid & m_axis.tready;
  assign pop      = ~i_pkt_start & ~fifo_empty &
                    ((state == IDLE) | ((state == HI) & accept));
  assign last_hit = (cfg_vecs_per_pkt != 16'd0) &&
                    (vec_cnt == cfg_vecs_per_pkt - 16'd1);
  assign o_busy   = ~fifo_empty | m_axis.tvalid;

  sync_fifo #(
    .W          (IN_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .clr       (i_pkt_start),
    .push      (i_valid & ~i_pkt_start),
    .wr_data   (i_data_vec),
    .pop       (pop),
    .rd_data   (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (o_fifo_level)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      vec_q         <= '0;
      vec_cnt       <= '0;
      o_overflow    <= 1'b0;
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else if (i_pkt_start) begin
      state         <= IDLE;
      vec_cnt       <= '0;
      o_overflow    <= 1'b0;
      m_axis.tvalid <= 1'b0;
      m_axis.tlast  <= 1'b0;
    end else begin
      if (i_valid && fifo_full && !pop)
        o_overflow <= 1'b1;
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            vec_q         <= head;
            m_axis.tdata  <= head[OUT_W-1:0];
            m_axis.tvalid <= 1'b1;
            m_axis.tlast  <= 1'b0;
            state         <= LO;
          end
        end
        LO: begin
          if (accept) begin
            m_axis.tdata <= vec_q[IN_W-1:OUT_W];
            m_axis.tlast <= last_hit;
            state        <= HI;
          end
        end
        HI: begin
          if (accept) begin
            vec_cnt <= last_hit ? 16'd0 : vec_cnt + 16'd1;
            // next vector goes out back-to-back when one is waiting
            if (!fifo_empty) begin
              vec_q         <= head;
              m_axis.tdata  <= head[OUT_W-1:0];
              m_axis.tlast  <= 1'b0;
              state         <= LO;
            end else begin
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_output_stream_packer.sv
// Directed bench for output_stream_packer: vector table
// plus backpressure, framing, overflow and abort sequences.
module tb_output_stream_packer;
  logic         clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_pkt_start = 1'b0;
  logic [127:0] i_data_vec = '0;
  logic [15:0]  cfg = '0;
  logic [4:0]   lvl;
  logic         ovf;
  logic         busy;

  output_stream_packer_if axis ();

  output_stream_packer dut (
    .clk              (clk),
    .sys_rst_n        (sys_rst_n),
    .i_valid          (i_valid),
    .i_data_vec       (i_data_vec),
    .cfg_vecs_per_pkt (cfg),
    .i_pkt_start      (i_pkt_start),
    .m_axis           (axis),
    .o_fifo_level     (lvl),
    .o_overflow       (ovf),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  cfg;
    logic [63:0]  lo;
    logic [63:0]  hi;
    logic         last;
  } vec_t;

  vec_t        tab [4];
  int          checks = 0;
  int          errors = 0;
  int          max_level = 0;
  logic [63:0] exp_d [$];
  logic        exp_l [$];

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] vec(input int k);
    return {32'(k), 32'hA5A5_0000 + 32'(k),
            32'(k * 3), 32'h1234_0000 ^ 32'(k)};
  endfunction

  task automatic pulse_start();
    i_pkt_start = 1'b1;
    tick();
    i_pkt_start = 1'b0;
  endtask

  task automatic push_burst(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      i_valid    = 1'b1;
      i_data_vec = vec(base + i);
      tick();
    end
    i_valid = 1'b0;
  endtask

  task automatic expect_vec(input int k, input logic last);
    logic [127:0] v;
    v = vec(k);
    exp_d.push_back(v[63:0]);
    exp_l.push_back(1'b0);
    exp_d.push_back(v[127:64]);
    exp_l.push_back(last);
  endtask

  // single vector into an idle block: LO at N+2, HI at N+3
  task automatic apply_vec(input string tag, input logic [127:0] d,
                           input logic [63:0] lo, input logic [63:0] hi,
                           input logic last);
    axis.tready = 1'b1;
    i_valid     = 1'b1;
    i_data_vec  = d;
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_n1_valid"}, axis.tvalid, 1'b0);
    tick();
    @(negedge clk);
    chk({tag, "_lo"}, {axis.tvalid, axis.tlast, axis.tdata},
        {1'b1, 1'b0, lo});
    tick();
    @(negedge clk);
    chk({tag, "_hi"}, {axis.tvalid, axis.tlast, axis.tdata},
        {1'b1, last, hi});
    tick();
    @(negedge clk);
    chk({tag, "_end_valid"}, axis.tvalid, 1'b0);
    tick();
  endtask

  task automatic drain(input string tag, input int per, input int budget);
    int          cyc = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [63:0] pd = '0;
    while (exp_d.size() != 0 && cyc < budget) begin
      axis.tready = (cyc % per == 0);
      @(negedge clk);
      if (int'(lvl) > max_level)
        max_level = int'(lvl);
      if (pv && !pr)
        chk({tag, "_hold"}, {axis.tvalid, axis.tlast, axis.tdata},
            {1'b1, pl, pd});
      if (axis.tvalid && axis.tready) begin
        chk({tag, "_data"}, axis.tdata, exp_d.pop_front());
        chk({tag, "_last"}, axis.tlast, exp_l.pop_front());
      end
      pv = axis.tvalid;
      pr = axis.tready;
      pl = axis.tlast;
      pd = axis.tdata;
      cyc++;
      tick();
    end
    if (exp_d.size() != 0) begin
      chk({tag, "_timeout_left"}, exp_d.size(), 0);
      exp_d.delete();
      exp_l.delete();
    end
  endtask

  initial begin
    logic [127:0] t;
    tab[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 16'd1,
               64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 1'b1};
    tab[1] = '{128'hDEADBEEFCAFEF00D0123456789ABCDEF, 16'd0,
               64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 1'b0};
    tab[2] = '{{128{1'b1}}, 16'd2,
               64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tab[3] = '{128'h0, 16'd1, 64'h0, 64'h0, 1'b1};

    axis.tready = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_outputs", {axis.tvalid, axis.tlast, axis.tdata, lvl, ovf, busy},
        '0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_idle", {axis.tvalid, lvl, ovf, busy}, '0);
    tick();

    for (int i = 0; i < 4; i++) begin
      cfg = tab[i].cfg;
      pulse_start();
      apply_vec($sformatf("tab%0d", i), tab[i].data, tab[i].lo,
                tab[i].hi, tab[i].last);
    end

    // backpressure: ready high one cycle in three
    cfg = 16'd0;
    pulse_start();
    axis.tready = 1'b0;
    max_level = 0;
    push_burst(4, 1);
    for (int k = 1; k <= 4; k++)
      expect_vec(k, 1'b0);
    drain("bp", 3, 200);
    chk("bp_max_level_le4", max_level <= 4, 1'b1);

    // framing: 3 vectors per packet, 7 vectors
    cfg = 16'd3;
    pulse_start();
    axis.tready = 1'b0;
    push_burst(7, 10);
    for (int k = 0; k < 7; k++)
      expect_vec(10 + k, (k == 2) || (k == 5));
    drain("frm", 1, 200);
    chk("frm_counter", dut.vec_cnt, 16'd1);

    // overflow: one vector sits in the beat slot, 16 in the FIFO
    cfg = 16'd0;
    pulse_start();
    axis.tready = 1'b0;
    push_burst(18, 20);
    @(negedge clk);
    chk("ovf_level", lvl, 5'd16);
    chk("ovf_flag", ovf, 1'b1);
    tick();
    for (int k = 0; k < 17; k++)
      expect_vec(20 + k, 1'b0);
    drain("ovf", 1, 300);
    @(negedge clk);
    chk("ovf_drained", {axis.tvalid, lvl, ovf}, {1'b0, 5'd0, 1'b1});
    tick();

    // abort while a HI beat is stalled
    cfg = 16'd1;
    axis.tready = 1'b0;
    push_burst(2, 50);
    tick();
    axis.tready = 1'b1;
    tick();
    axis.tready = 1'b0;
    tick();
    @(negedge clk);
    t = vec(50);
    chk("abt_stalled_hi", {axis.tvalid, axis.tdata}, {1'b1, t[127:64]});
    tick();
    pulse_start();
    @(negedge clk);
    chk("abt_cleared", {axis.tvalid, lvl, ovf}, '0);
    tick();
    t = vec(60);
    apply_vec("abt_new", t, t[63:0], t[127:64], 1'b1);

    // asynchronous reset in the middle of a burst
    cfg = 16'd0;
    axis.tready = 1'b1;
    push_burst(3, 70);
    tick();
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("arst_outputs",
        {axis.tvalid, axis.tlast, axis.tdata, lvl, ovf, busy}, '0);
    chk("arst_counter", dut.vec_cnt, 16'd0);
    tick();
    sys_rst_n = 1'b1;
    tick();
    t = vec(80);
    apply_vec("arst_new", t, t[63:0], t[127:64], 1'b0);

    // full FIFO with a pop in the same cycle as a push
    pulse_start();
    axis.tready = 1'b0;
    push_burst(17, 90);
    @(negedge clk);
    chk("full_level", {lvl, ovf}, {5'd16, 1'b0});
    tick();
    axis.tready = 1'b1;
    tick();
    i_valid    = 1'b1;
    i_data_vec = vec(110);
    tick();
    i_valid     = 1'b0;
    axis.tready = 1'b0;
    @(negedge clk);
    chk("full_push_pop", {lvl, ovf}, {5'd16, 1'b0});
    t = vec(91);
    chk("full_next_lo", {axis.tvalid, axis.tdata}, {1'b1, t[63:0]});
    tick();
    pulse_start();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
